// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package mdu_pkg;

  localparam int MDU_XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  // Most negative dividend; divided by -1 it overflows the signed quotient.
  localparam logic [MDU_XLEN-1:0] DIV_OVF_DIVIDEND = {1'b1, {(MDU_XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_datapath.sv
// Shift-add multiplier / restoring divider sharing one 2W register.
// Multiply keeps {accumulator, multiplier}; divide keeps {remainder, quotient}.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int W = MDU_XLEN
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           load,
  input  logic           step,
  input  logic           fix,
  input  mdu_op_t        op,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  output logic [2*W-1:0] fixed
);

  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic           is_div_q, is_div_d;
  logic           neg_lo_q, neg_lo_d;
  logic           neg_hi_q, neg_hi_d;

  logic [W-1:0]   abs1, abs2, ld_a, ld_b;
  logic           ld_neg_lo, ld_neg_hi;
  logic [W:0]     mul_sum, div_tmp, div_diff;
  logic [2*W-1:0] mul_next, div_next;

  always_comb begin
    abs1      = src1[W-1] ? -src1 : src1;
    abs2      = src2[W-1] ? -src2 : src2;
    ld_a      = src1;
    ld_b      = src2;
    ld_neg_lo = 1'b0;
    ld_neg_hi = 1'b0;
    case (op)
      OP_MULH: begin
        ld_a      = abs1;
        ld_b      = abs2;
        ld_neg_lo = src1[W-1] ^ src2[W-1];
      end
      OP_MULHSU: begin
        ld_a      = abs1;
        ld_neg_lo = src1[W-1];
      end
      OP_DIV, OP_REM: begin
        ld_a      = abs1;
        ld_b      = abs2;
        ld_neg_lo = src1[W-1] ^ src2[W-1];
        ld_neg_hi = src1[W-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[W-1:1]};
    // Partial remainder is below the divisor, so shifting in one bit fits in W+1.
    div_tmp  = {prod_q[2*W-1:W], prod_q[W-1]};
    div_diff = div_tmp - {1'b0, mcand_q};
    div_next = div_diff[W] ? {div_tmp[W-1:0], prod_q[W-2:0], 1'b0}
                           : {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
  end

  always_comb begin
    if (is_div_q)
      fixed = {(neg_hi_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W]),
               (neg_lo_q ? -prod_q[W-1:0]   : prod_q[W-1:0])};
    else
      fixed = neg_lo_q ? -prod_q : prod_q;
  end

  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (load) begin
      prod_d   = {{W{1'b0}}, ld_a};
      mcand_d  = ld_b;
      is_div_d = op[2];
      neg_lo_d = ld_neg_lo;
      neg_hi_d = ld_neg_hi;
    end else if (step) begin
      prod_d = is_div_q ? div_next : mul_next;
    end else if (fix) begin
      prod_d = fixed;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV64M execute-stage sequencer: FSM, iteration counter and pipeline stall,
// driving mdu_datapath through load/step/fix strobes.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_XLEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_src1,
  input  logic [DATA_WIDTH-1:0] i_src2,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_busy,
  output mdu_state_t            o_dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  mdu_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  mdu_op_t               op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  valid_q, valid_d;
  logic [W-1:0]          result_q, result_d;
  logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;

  logic                  dp_load, dp_step, dp_fix;
  logic [2*W-1:0]        dp_fixed;
  logic                  div_zero, div_ovf, special;
  logic [W-1:0]          special_res, fix_res;

  mdu_datapath #(.W(W)) u_datapath (
    .clk    (i_clk),
    .arst_n (i_arst),
    .load   (dp_load),
    .step   (dp_step),
    .fix    (dp_fix),
    .op     (mdu_op_t'(i_op)),
    .src1   (i_src1),
    .src2   (i_src2),
    .fixed  (dp_fixed)
  );

  always_comb begin
    div_zero = i_op[2] && (i_src2 == '0);
    div_ovf  = i_op[2] && !i_op[0] && (i_src1 == DIV_OVF_DIVIDEND) && (i_src2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_res = i_op[1] ? i_src1 : '1;
    else
      special_res = i_op[1] ? '0 : i_src1;
  end

  // Low half holds the product low word or the quotient; high half the rest.
  always_comb begin
    case (op_q)
      OP_MUL, OP_DIV, OP_DIVU: fix_res = dp_fixed[W-1:0];
      default:                 fix_res = dp_fixed[2*W-1:W];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    valid_d  = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    dp_fix   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          op_d = mdu_op_t'(i_op);
          rd_d = i_rd_addr;
          if (special) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = special_res;
            rd_out_d = i_rd_addr;
          end else begin
            dp_load = 1'b1;
            cnt_d   = CW'(W);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        dp_fix   = 1'b1;
        state_d  = S_DONE;
        valid_d  = 1'b1;
        result_d = fix_res;
        rd_out_d = rd_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      op_d     = op_q;
      rd_d     = rd_q;
      valid_d  = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
      dp_load  = 1'b0;
      dp_step  = 1'b0;
      dp_fix   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Handshake: i_start is held until the stage advances; o_stall holds the
  // pipeline until the single-cycle o_valid pulse, which the stage captures.
  assign o_stall     = i_start & ~valid_q & ~i_flush;
  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_rd_addr   = rd_out_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: cycle-accurate latency, sign rules,
// special divides, flush and asynchronous reset abort.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic             clk = 1'b0;
  logic             i_arst;
  logic             i_start;
  logic [2:0]       i_op;
  logic [63:0]      i_src1, i_src2;
  logic [4:0]       i_rd_addr;
  logic             i_flush;
  logic             o_stall, o_valid, o_busy;
  logic [63:0]      o_result;
  logic [4:0]       o_rd_addr;
  mdu_state_t       o_dbg_state;

  int errors = 0;
  int checks = 0;

  mdu_sequencer #(.DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
    .i_clk       (clk),
    .i_arst      (i_arst),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_src1      (i_src1),
    .i_src2      (i_src2),
    .i_rd_addr   (i_rd_addr),
    .i_flush     (i_flush),
    .o_stall     (o_stall),
    .o_valid     (o_valid),
    .o_result    (o_result),
    .o_rd_addr   (o_rd_addr),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next negedge (cycle 0) and hold i_start until o_valid.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp_res, input int exp_cyc);
    int  c;
    int  bad_stall;
    bit  done;
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_src1 = a; i_src2 = b; i_rd_addr = rd;
    #1;
    c = 0; bad_stall = 0; done = 1'b0;
    while (!done && c < 200) begin
      if (o_valid === 1'b1) begin
        done = 1'b1;
        check({tag, " cycle"}, 64'(c), 64'(exp_cyc));
        check({tag, " result"}, o_result, exp_res);
        check({tag, " rd"}, 64'(o_rd_addr), 64'(rd));
        check({tag, " stall_in_done"}, 64'(o_stall), 64'(0));
      end else begin
        if (o_stall !== 1'b1) bad_stall++;
        @(negedge clk);
        #1;
        c++;
      end
    end
    check({tag, " completed"}, 64'(done), 64'(1));
    check({tag, " stall_cycles"}, 64'(bad_stall), 64'(0));
    @(negedge clk);
    i_start = 1'b0;
    #1;
    check({tag, " one_cycle_valid"}, 64'(o_valid), 64'(0));
    check({tag, " idle_after"}, 64'(o_busy), 64'(0));
  endtask

  initial begin
    int seen;
    i_arst = 1'b0; i_start = 1'b0; i_op = 3'd0; i_src1 = '0; i_src2 = '0;
    i_rd_addr = '0; i_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset valid", 64'(o_valid), 64'(0));
    check("reset result", o_result, 64'(0));
    check("reset rd", 64'(o_rd_addr), 64'(0));
    check("reset busy", 64'(o_busy), 64'(0));
    check("reset stall", 64'(o_stall), 64'(0));
    check("reset state", 64'(o_dbg_state), 64'(S_IDLE));
    @(negedge clk);
    i_arst = 1'b1;

    run_op("mul 7x-3", 3'd0, 64'd7, -64'sd3, 5'd3, -64'sd21, 66);
    run_op("mulhu max", 3'd3, '1, '1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run_op("mulh -1x-1", 3'd1, '1, '1, 5'd5, 64'd0, 66);
    run_op("mulhsu", 3'd2, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("div -7/2", 3'd4, -64'sd7, 64'd2, 5'd7, -64'sd3, 66);
    run_op("rem -7/2", 3'd6, -64'sd7, 64'd2, 5'd8, -64'sd1, 66);
    run_op("divu 100/7", 3'd5, 64'd100, 64'd7, 5'd9, 64'd14, 66);
    run_op("remu 100/7", 3'd7, 64'd100, 64'd7, 5'd10, 64'd2, 66);
    run_op("div 5/0", 3'd4, 64'd5, 64'd0, 5'd11, '1, 1);
    run_op("rem 5/0", 3'd6, 64'd5, 64'd0, 5'd12, 64'd5, 1);
    run_op("div ovf", 3'd4, 64'h8000_0000_0000_0000, '1, 5'd13, 64'h8000_0000_0000_0000, 1);
    run_op("rem ovf", 3'd6, 64'h8000_0000_0000_0000, '1, 5'd14, 64'd0, 1);

    // Flush a DIVU at cycle 20, then start MUL 3x4 at cycle 22.
    @(negedge clk);
    i_start = 1'b1; i_op = 3'd5; i_src1 = 64'd100; i_src2 = 64'd7; i_rd_addr = 5'd15;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      #1;
      if (o_valid === 1'b1) seen++;
    end
    i_flush = 1'b1;
    #1;
    check("flush stall masked", 64'(o_stall), 64'(0));
    @(negedge clk);
    i_flush = 1'b0; i_start = 1'b0;
    #1;
    if (o_valid === 1'b1) seen++;
    check("flush busy low", 64'(o_busy), 64'(0));
    check("flush state idle", 64'(o_dbg_state), 64'(S_IDLE));
    check("flush no valid", 64'(seen), 64'(0));
    run_op("mul 3x4 after flush", 3'd0, 64'd3, 64'd4, 5'd16, 64'd12, 66);

    // Asynchronous reset in cycle 30 of a MUL.
    @(negedge clk);
    i_start = 1'b1; i_op = 3'd0; i_src1 = 64'd123; i_src2 = 64'd456; i_rd_addr = 5'd17;
    repeat (30) @(negedge clk);
    #1;
    check("pre-reset busy", 64'(o_busy), 64'(1));
    i_arst = 1'b0; i_start = 1'b0;
    #1;
    check("arst valid", 64'(o_valid), 64'(0));
    check("arst result", o_result, 64'(0));
    check("arst rd", 64'(o_rd_addr), 64'(0));
    check("arst busy", 64'(o_busy), 64'(0));
    check("arst state", 64'(o_dbg_state), 64'(S_IDLE));
    @(negedge clk);
    i_arst = 1'b1;
    run_op("div 9/3 after reset", 3'd4, 64'd9, 64'd3, 5'd18, 64'd3, 66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
